// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver with a one-entry output register.
//
// Ports:
//   clk        system clock
//   res_n      asynchronous active-low reset
//   rx         serial line input, idle high, asynchronous to clk
//   data       last received byte
//   data_valid level, data holds an unread byte
//   rd         consumer acknowledge, clears data_valid on the next cycle
//   frame_err  one-cycle pulse, stop bit sampled low
//   overrun    one-cycle pulse, a new byte overwrote an unread byte
//   busy       high whenever the receive FSM is not idle
module uart_rx #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 921600
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       rd,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

    // Sampling at mid-bit needs at least a few clocks per bit.
    if (DIV < 4) begin : g_div_check
        $fatal(1, "uart_rx: CLK_FREQ/BAUD must be at least 4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state, state_next;
    logic [1:0]       sync;
    logic             rx_s;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shreg, shreg_next;
    logic [7:0]       data_next;
    logic             data_valid_next;
    logic             frame_err_next;
    logic             overrun_next;
    logic             busy_next;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx};
        end
    end

    assign rx_s = sync[1];

    // State and datapath registers.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            bit_idx    <= bit_idx_next;
            shreg      <= shreg_next;
            data       <= data_next;
            data_valid <= data_valid_next;
            frame_err  <= frame_err_next;
            overrun    <= overrun_next;
            busy       <= busy_next;
        end
    end

    // Next-state, counter, shift register and handshake logic.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        bit_idx_next    = bit_idx;
        shreg_next      = shreg;
        data_next       = data;
        data_valid_next = data_valid;
        frame_err_next  = 1'b0;
        overrun_next    = 1'b0;

        if (rd && data_valid) begin
            data_valid_next = 1'b0;
        end

        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_next = S_START;
                    cnt_next   = CNT_HALF;
                end
            end

            S_START: begin
                if (cnt == '0) begin
                    if (rx_s) begin
                        // Line went back high before mid-start: glitch.
                        state_next = S_IDLE;
                    end else begin
                        state_next   = S_DATA;
                        cnt_next     = CNT_DIV;
                        bit_idx_next = 3'd0;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end

            S_DATA: begin
                if (cnt == '0) begin
                    shreg_next = {rx_s, shreg[7:1]};
                    cnt_next   = CNT_DIV;
                    if (bit_idx == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end

            S_STOP: begin
                if (cnt == '0) begin
                    if (rx_s) begin
                        // New byte wins over a same-cycle read.
                        data_next       = shreg;
                        data_valid_next = 1'b1;
                        overrun_next    = data_valid && !rd;
                        state_next      = S_IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = S_BREAK;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end

            S_BREAK: begin
                // Hold off until the line returns high so a stuck-low
                // line cannot retrigger a start.
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at DIV=16, HALF=8.
module tb_uart_rx;

    localparam int unsigned CLK_FREQ = 16;
    localparam int unsigned BAUD     = 1;
    localparam int unsigned DIV      = 16;
    localparam int unsigned HALF     = 8;
    localparam int unsigned LAT      = 2 + HALF + 9 * DIV;

    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_ovr   = 0;
    int   n_ferr  = 0;
    logic dv_prev = 1'b0;
    logic rd_edge;
    exp_t mon_e;

    uart_rx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk       (clk),
        .res_n     (res_n),
        .rx        (rx),
        .data      (data),
        .data_valid(data_valid),
        .rd        (rd),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one frame starting at the current time (caller sits at a negedge).
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit push);
        exp_t e;
        if (push) begin
            e.data = b;
            e.ferr = !stop_bit;
            sb_q.push_back(e);
        end
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop_bit;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    // Monitor: a new byte shows as data_valid rising, an overrun pulse, or
    // data_valid surviving a read; a frame error pops a frame-error entry.
    initial begin
        forever begin
            @(posedge clk);
            rd_edge = rd;
            #1;
            if (overrun) n_ovr++;
            if (frame_err) n_ferr++;
            if ((data_valid && (!dv_prev || rd_edge)) || overrun || frame_err) begin
                check("sb_nonempty", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    check("evt_kind", 32'(frame_err), 32'(mon_e.ferr));
                    if (!mon_e.ferr) check("rx_data", 32'(data), 32'(mon_e.data));
                end
            end
            dv_prev = data_valid;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data), 0);
        check("rst_dv", 32'(data_valid), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_ovr", 32'(overrun), 0);
        check("rst_busy", 32'(busy), 0);
        res_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic frame with exact data_valid timing.
        fork
            send_frame(8'hA5, 1'b1, 1'b1);
            begin
                repeat (LAT) @(posedge clk);
                @(negedge clk);
                check("a5_dv_early", 32'(data_valid), 0);
                check("a5_busy", 32'(busy), 1);
                @(negedge clk);
                check("a5_dv_on_time", 32'(data_valid), 1);
                check("a5_data", 32'(data), 32'hA5);
            end
        join
        check("a5_ferr_cnt", 32'(n_ferr), 0);
        check("a5_ovr_cnt", 32'(n_ovr), 0);
        check("a5_busy_idle", 32'(busy), 0);

        // Handshake.
        repeat (50) @(negedge clk);
        check("hs_dv_hold", 32'(data_valid), 1);
        pulse_rd();
        check("hs_dv_clr", 32'(data_valid), 0);
        check("hs_data_kept", 32'(data), 32'hA5);
        pulse_rd();
        check("hs_rd_ignored", 32'(data_valid), 0);

        // Overrun: two back-to-back frames, no read.
        send_frame(8'h3C, 1'b1, 1'b1);
        send_frame(8'hC3, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("ovr_cnt", 32'(n_ovr), 1);
        check("ovr_data", 32'(data), 32'hC3);
        check("ovr_dv", 32'(data_valid), 1);
        pulse_rd();
        check("ovr_dv_clr", 32'(data_valid), 0);

        // Read in the very cycle the second byte completes.
        send_frame(8'h3C, 1'b1, 1'b1);
        fork
            send_frame(8'hC3, 1'b1, 1'b1);
            begin
                repeat (LAT) @(posedge clk);
                @(negedge clk);
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check("sim_ovr_cnt", 32'(n_ovr), 1);
        check("sim_dv", 32'(data_valid), 1);
        check("sim_data", 32'(data), 32'hC3);

        // Framing error with an unread byte present, then a held-low break.
        send_frame(8'h55, 1'b0, 1'b1);
        @(negedge clk);
        check("fe_cnt", 32'(n_ferr), 1);
        check("fe_dv_kept", 32'(data_valid), 1);
        check("fe_data_kept", 32'(data), 32'hC3);
        repeat (100) @(negedge clk);
        check("brk_busy", 32'(busy), 1);
        check("brk_fe_once", 32'(n_ferr), 1);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("brk_release", 32'(busy), 0);
        pulse_rd();
        send_frame(8'h0F, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("post_brk_data", 32'(data), 32'h0F);
        check("post_brk_dv", 32'(data_valid), 1);

        // False start: three low cycles only.
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check("fs_busy", 32'(busy), 1);
        repeat (20) @(negedge clk);
        check("fs_idle", 32'(busy), 0);
        check("fs_data", 32'(data), 32'h0F);
        check("fs_ferr_cnt", 32'(n_ferr), 1);

        // Reset during data bit 4, held until the line is idle again.
        fork
            send_frame(8'h99, 1'b1, 1'b0);
            begin
                repeat (5 * DIV + 5) @(posedge clk);
                @(negedge clk);
                res_n = 1'b0;
                #1;
                check("mrst_data", 32'(data), 0);
                check("mrst_dv", 32'(data_valid), 0);
                check("mrst_busy", 32'(busy), 0);
                check("mrst_ferr", 32'(frame_err), 0);
                check("mrst_ovr", 32'(overrun), 0);
            end
        join
        repeat (3) @(negedge clk);
        res_n = 1'b1;
        repeat (4) @(negedge clk);
        fork
            send_frame(8'h81, 1'b1, 1'b1);
            begin
                repeat (LAT) @(posedge clk);
                @(negedge clk);
                check("r81_dv_early", 32'(data_valid), 0);
                @(negedge clk);
                check("r81_dv_on_time", 32'(data_valid), 1);
                check("r81_data", 32'(data), 32'h81);
            end
        join
        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 0);
        check("final_ovr_cnt", 32'(n_ovr), 1);
        check("final_ferr_cnt", 32'(n_ferr), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
